seg7_scan_decoder: RTL
======================

// Module: seg7_scan_decoder
// PURPOSE
//  Receive-side counterpart of the BCD-to-7-segment encoder. Snoops a multiplexed
//  display bus (digit select plus shared segment code), waits for each digit's code
//  to be stable, and decodes it back to a BCD nibble. Once every digit has been
//  captured it presents one frame on a valid/ready port. Used for display readback,
//  self-check and loopback tests of the counter/display path.
// PARAMETERS
//  NUM_DIGITS     4  number of multiplexed digits (>=1)
//  STABLE_CYCLES  4  consecutive identical samples needed before a capture (>=1)
// PORTS
//  clk             in   1             system clock; the block's only clock
//  rst_n           in   1             reset: synchronous, active-low
//  dig_sel_in      in   NUM_DIGITS    active-low one-hot digit enable; bit i = digit i
//  disp_code_in    in   8             [7]=dp, [6:0]=gfedcba, all active-low
//  bcd_out         out  4*NUM_DIGITS  nibble of digit i at [4i+3:4i]
//  dp_out          out  NUM_DIGITS    1 = decimal point lit on digit i
//  code_err_out    out  NUM_DIGITS    1 = digit i held an illegal segment code
//  frame_valid_out out  1             frame data valid; held until accepted
//  frame_ready_in  in   1             consumer accepts the frame
//  overrun_out     out  1             sticky: a completed frame was dropped
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): every output is 0. Input regs, stability counter,
//    capture slots and the seen mask are cleared. A reset during a frame discards
//    the partial frame.
//  - Stage 0: dig_sel_in and disp_code_in are registered together.
//  - Legal select: exactly one bit of the registered dig_sel is 0. If zero or several
//    bits are 0, the stability counter and the captured flag are cleared.
//  - Stability: the counter increments while the registered {sel,code} is legal and
//    equal to the previous cycle's value. Any change reloads the counter to 1.
//    - The capture fires once, on the cycle the count reaches STABLE_CYCLES.
//    - The captured flag then blocks recapture until {sel,code} changes.
//    - The counter saturates; it must not wrap.
//  - Decode (6:0, active-low) to nibble/err:
//    - 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4
//    - 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9
//    - 1111111 -> 4'hF, err=0 (blank)
//    - any other code -> 4'hE, err=1
//    - dp = ~code[7]
//  - Capture writes slot i (nibble, dp, err) and sets seen[i]. Recapturing a digit
//    before the frame completes overwrites that slot.
//  - Frame complete: the cycle seen becomes all-ones.
//    - If the output is free (frame_valid_out=0, or frame_valid_out=1 with
//      frame_ready_in=1 in that same cycle), slots load into the output regs and
//      frame_valid_out is 1 on the next cycle.
//    - Otherwise the frame is dropped and overrun_out is set to 1.
//    - In both cases the seen mask is cleared.
//  - Handshake: frame_valid_out=1 with frame_ready_in=1 at an edge completes the
//    transfer; valid falls unless a new frame loads in that same cycle.
//    bcd_out, dp_out and code_err_out stay constant while valid=1 and ready=0.
//  - overrun_out clears only on reset.
//  - Latency from pins stable to capture: 1 + STABLE_CYCLES cycles. frame_valid_out
//    rises 1 cycle after the last digit is captured.
// STRUCTURE
//  - Package seg7_pkg holds:
//    - SEG_0..SEG_9 and SEG_BLANK 7-bit active-low codes (shared with the encoder)
//    - NIB_BLANK=4'hF and NIB_ERR=4'hE
//  - One combinational sub-module, seg7_code_decoder: 8-bit code in, {nibble, dp,
//    err} out.
//  - This block holds the input regs, stability counter, slot array, seen mask and
//    output/handshake regs.
// TESTING
//  1 Scan digits 0..3 with codes 1111001, 0100100, 0110000, 0011001, 6 cycles each,
//    ready=1 -> one valid pulse, bcd_out=16'h4321, dp_out=0, code_err_out=0.
//  2 Dwell of STABLE_CYCLES-1 cycles on digit 2, then move on -> no capture, seen[2]=0,
//    no frame. Dwell of exactly STABLE_CYCLES -> captured.
//  3 Digit 1 shows 0101010 with dp low -> nibble 4'hE, code_err_out[1]=1, dp_out[1]=1.
//    Code 1111111 -> 4'hF, err=0.
//  4 ready=0, two full frames scanned -> first frame held unchanged, overrun_out=1.
//    Then ready=1 -> valid drops next cycle.
//  5 Frame completes in the same cycle as an accept -> valid stays 1, new data loaded.
//  6 rst_n=0 for 1 cycle after 2 digits captured -> all outputs 0. After a full
//    rescan only the new values appear.
//    Plus: sel=4'b1100 (two digits active) for 10 cycles -> no capture.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment code constants and the decoded-digit record used by the
// scan decoder and its code decoder.
package seg7_pkg;

  // Active-low gfedcba codes, identical to the ones the encoder drives.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] NIB_BLANK = 4'hF;
  localparam logic [3:0] NIB_ERR   = 4'hE;

  typedef struct packed {
    logic [3:0] nib;
    logic       dp;
    logic       err;
  } seg7_dec_t;

endpackage

// File: rtl/seg7_code_decoder.sv
// Combinational inverse of the BCD-to-7-segment encoder: one 8-bit bus code
// (dp + gfedcba, active-low) to nibble, decimal point and illegal-code flag.
module seg7_code_decoder
  import seg7_pkg::*;
(
  input  logic [7:0] code_i,
  output seg7_dec_t  dec_o
);

  always_comb begin
    dec_o.dp  = ~code_i[7];
    dec_o.err = 1'b0;
    case (code_i[6:0])
      SEG_0:     dec_o.nib = 4'h0;
      SEG_1:     dec_o.nib = 4'h1;
      SEG_2:     dec_o.nib = 4'h2;
      SEG_3:     dec_o.nib = 4'h3;
      SEG_4:     dec_o.nib = 4'h4;
      SEG_5:     dec_o.nib = 4'h5;
      SEG_6:     dec_o.nib = 4'h6;
      SEG_7:     dec_o.nib = 4'h7;
      SEG_8:     dec_o.nib = 4'h8;
      SEG_9:     dec_o.nib = 4'h9;
      SEG_BLANK: dec_o.nib = NIB_BLANK;
      default: begin
        dec_o.nib = NIB_ERR;
        dec_o.err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed 7-segment bus, captures each digit once its select and
// code have been stable long enough, and emits whole frames on valid/ready.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   dig_sel_in,
  input  logic [7:0]              disp_code_in,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [NUM_DIGITS-1:0]   code_err_out,
  output logic                    frame_valid_out,
  input  logic                    frame_ready_in,
  output logic                    overrun_out
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  typedef logic [CW-1:0] cnt_t;
  // Down-counter of samples still needed; IDLE marks "no legal run in progress".
  localparam cnt_t CNT_IDLE = cnt_t'(STABLE_CYCLES);
  localparam cnt_t CNT_LOAD = cnt_t'(STABLE_CYCLES - 1);

  logic [NUM_DIGITS-1:0]   sel_q, prev_sel_q;
  logic [7:0]              code_q, prev_code_q;
  cnt_t                    rem_q, rem_d;
  logic                    captured_q, captured_d;
  logic [4*NUM_DIGITS-1:0] slot_bcd_q, slot_bcd_d;
  logic [NUM_DIGITS-1:0]   slot_dp_q, slot_dp_d;
  logic [NUM_DIGITS-1:0]   slot_err_q, slot_err_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d, err_q, err_d;
  logic                    valid_q, valid_d, overrun_q, overrun_d;

  logic                  legal, changed, capture, complete, out_free, load;
  logic [NUM_DIGITS-1:0] cap_mask;
  seg7_dec_t             dec;

  seg7_code_decoder u_dec (
    .code_i (code_q),
    .dec_o  (dec)
  );

  assign legal   = $onehot(~sel_q);
  assign changed = {sel_q, code_q} != {prev_sel_q, prev_code_q};

  always_comb begin
    rem_d      = rem_q;
    captured_d = captured_q;
    capture    = 1'b0;
    if (!legal) begin
      rem_d      = CNT_IDLE;
      captured_d = 1'b0;
    end else begin
      if (changed) begin
        rem_d      = CNT_LOAD;
        captured_d = 1'b0;
      end else if (rem_q != '0) begin
        rem_d = rem_q - cnt_t'(1);
      end
      capture = (rem_d == '0) && !captured_d;
      if (capture) captured_d = 1'b1;
    end
  end

  assign cap_mask = capture ? ~sel_q : '0;
  assign complete = &seen_q;
  assign out_free = !valid_q || frame_ready_in;
  assign load     = complete && out_free;

  always_comb begin
    slot_bcd_d = slot_bcd_q;
    slot_dp_d  = slot_dp_q;
    slot_err_d = slot_err_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cap_mask[i]) begin
        slot_bcd_d[4*i +: 4] = dec.nib;
        slot_dp_d[i]         = dec.dp;
        slot_err_d[i]        = dec.err;
      end
    end
    // A capture landing on the completion cycle starts the next frame.
    seen_d    = (complete ? '0 : seen_q) | cap_mask;
    bcd_d     = load ? slot_bcd_q : bcd_q;
    dp_d      = load ? slot_dp_q  : dp_q;
    err_d     = load ? slot_err_q : err_q;
    valid_d   = load ? 1'b1 : (frame_ready_in ? 1'b0 : valid_q);
    overrun_d = overrun_q | (complete && !out_free);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q       <= '0;
      code_q      <= '0;
      prev_sel_q  <= '0;
      prev_code_q <= '0;
      rem_q       <= CNT_IDLE;
      captured_q  <= 1'b0;
      slot_bcd_q  <= '0;
      slot_dp_q   <= '0;
      slot_err_q  <= '0;
      seen_q      <= '0;
      bcd_q       <= '0;
      dp_q        <= '0;
      err_q       <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sel_q       <= dig_sel_in;
      code_q      <= disp_code_in;
      prev_sel_q  <= sel_q;
      prev_code_q <= code_q;
      rem_q       <= rem_d;
      captured_q  <= captured_d;
      slot_bcd_q  <= slot_bcd_d;
      slot_dp_q   <= slot_dp_d;
      slot_err_q  <= slot_err_d;
      seen_q      <= seen_d;
      bcd_q       <= bcd_d;
      dp_q        <= dp_d;
      err_q       <= err_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bcd_out         = bcd_q;
  assign dp_out          = dp_q;
  assign code_err_out    = err_q;
  assign frame_valid_out = valid_q;
  assign overrun_out     = overrun_q;

endmodule
